// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for the pipelined add/subtract unit
//
// Contents:
//   OP_ADD / OP_SUB   encodings of the SUB input
//   chunk_width()     bits handled by one carry-pipeline stage
//   prep_carry()      carry-in seen by the adder core for a given operation
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // A - B - borrow is computed as A + ~B + ~borrow, so the carry-in sense flips for subtract.
    function automatic logic prep_carry(input logic cin, input logic sub);
        return (sub == OP_SUB) ? ~cin : cin;
    endfunction

endpackage

// File: rtl/add_chunk_stage.sv
// rtl/add_chunk_stage.sv - one carry-pipelined chunk of the add/subtract unit
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   en           pipeline advance; when low the carry and valid registers hold
//   a, b         CW-bit operand chunk (b already conditioned for subtract)
//   cin          carry into this chunk (registered carry of the previous stage)
//   valid_in     beat-valid bit travelling alongside the chunk
//   sum          combinational chunk sum, captured by the parent's alignment registers
//   cout_q       registered carry out of this chunk
//   valid_q      registered beat-valid bit
module add_chunk_stage #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    input  logic          valid_in,
    output logic [CW-1:0] sum,
    output logic          cout_q,
    output logic          valid_q
);

    logic cout_d;
    logic valid_d;

    always_comb begin
        {cout_d, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        valid_d       = valid_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - parametrised carry-pipelined add/subtract unit with valid/ready handshake
//
// Ports:
//   CLK, RST_N           rising-edge clock, synchronous active-low reset
//   IN_VALID, IN_READY   operand beat handshake (IN_READY = advance & RST_N)
//   A, B, CIN, SUB       operands; SUB=0: A+B+CIN, SUB=1: A-B-CIN
//   OUT_VALID, OUT_READY result beat handshake
//   SUM                  result modulo 2^WIDTH
//   COUT                 raw carry out of the MSB (for subtract, 1 = no borrow)
//   OVF                  signed two's-complement overflow
//   ZERO                 SUM == 0
//
// Datapath: an input register captures A, the conditioned B' and carry-in. Stage k then adds
// the lowest chunk of its operand words. The A word doubles as the result word: each stage
// shifts it right by one chunk and drops its sum chunk in at the top, so after STAGES stages
// the word holds the fully aligned result. The B' word simply shifts right. The whole pipeline
// moves together on advance; a beat accepted at edge t is on the outputs after edge t+STAGES.
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_add_sub: WIDTH must be a positive multiple of STAGES");
    end

    // Handshake
    logic advance;
    logic in_ready;
    logic out_valid;

    // Input register
    logic in_v_q;
    logic in_v_d;
    logic c0_q;
    logic c0_d;

    // Operand/result words: index k feeds stage k, index STAGES is the result register.
    logic [WIDTH-1:0] word_a_q [STAGES+1];
    logic [WIDTH-1:0] word_a_d [STAGES+1];
    logic [WIDTH-1:0] word_b_q [STAGES];
    logic [WIDTH-1:0] word_b_d [STAGES];

    // Per-stage chunk adder connections
    logic [STAGES-1:0][CW-1:0] chunk_sum;
    logic [STAGES-1:0]         stage_cin;
    logic [STAGES-1:0]         stage_vin;
    logic [STAGES-1:0]         stage_cout;
    logic [STAGES-1:0]         stage_vout;

    // Registered flags
    logic ovf_q;
    logic ovf_d;
    logic zero_q;
    logic zero_d;

    // Global stall: nothing moves while a result waits for the consumer.
    always_comb begin
        advance  = ~out_valid | OUT_READY;
        in_ready = advance & RST_N;
        in_v_d   = IN_VALID & in_ready;
        c0_d     = prep_carry(CIN, SUB);
    end

    always_comb begin
        stage_cin    = '0;
        stage_vin    = '0;
        stage_cin[0] = c0_q;
        stage_vin[0] = in_v_q;
        for (int k = 1; k < STAGES; k++) begin
            stage_cin[k] = stage_cout[k-1];
            stage_vin[k] = stage_vout[k-1];
        end
    end

    always_comb begin
        word_a_d[0] = A;
        word_b_d[0] = (SUB == OP_SUB) ? ~B : B;
        for (int k = 1; k < STAGES; k++) begin
            word_b_d[k] = word_b_q[k-1] >> CW;
        end
        for (int k = 0; k < STAGES; k++) begin
            // Consumed A chunk leaves at the bottom, finished sum chunk enters at the top.
            word_a_d[k+1] = (word_a_q[k] >> CW) | (WIDTH'(chunk_sum[k]) << (WIDTH - CW));
        end
        // At the last stage the low chunks of the operand words carry the sign bits of A and B'.
        ovf_d  = (word_a_q[STAGES-1][CW-1] == word_b_q[STAGES-1][CW-1]) &&
                 (chunk_sum[STAGES-1][CW-1] != word_a_q[STAGES-1][CW-1]);
        zero_d = (word_a_d[STAGES] == '0);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk_stage #(
            .CW (CW)
        ) u_chunk (
            .clk      (CLK),
            .rst_n    (RST_N),
            .en       (advance),
            .a        (word_a_q[k][CW-1:0]),
            .b        (word_b_q[k][CW-1:0]),
            .cin      (stage_cin[k]),
            .valid_in (stage_vin[k]),
            .sum      (chunk_sum[k]),
            .cout_q   (stage_cout[k]),
            .valid_q  (stage_vout[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            in_v_q <= 1'b0;
            c0_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                word_a_q[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                word_b_q[k] <= '0;
            end
        end else if (advance) begin
            in_v_q <= in_v_d;
            c0_q   <= c0_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k <= STAGES; k++) begin
                word_a_q[k] <= word_a_d[k];
            end
            for (int k = 0; k < STAGES; k++) begin
                word_b_q[k] <= word_b_d[k];
            end
        end
    end

    assign out_valid = stage_vout[STAGES-1];
    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign SUM       = word_a_q[STAGES];
    assign COUT      = stage_cout[STAGES-1];
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - self-checking bench for pipelined_add_sub
module tb_pipelined_add_sub;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
    } beat_t;

    logic         CLK;
    logic         RST_N;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIN;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;
    logic         ZERO;

    int    checks    = 0;
    int    errors    = 0;
    int    cycle_cnt = 0;
    beat_t exp_q[$];
    beat_t idle;

    pipelined_add_sub #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF),
        .ZERO      (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation as written, not on the adder structure.
    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub);
        beat_t t;
        int    r;
        int    sr;
        t.a   = a;
        t.b   = b;
        t.cin = cin;
        t.sub = sub;
        if (sub) begin
            r      = int'(a) - int'(b) - int'(cin);
            sr     = int'($signed(a)) - int'($signed(b)) - int'(cin);
            t.cout = (r >= 0);
        end else begin
            r      = int'(a) + int'(b) + int'(cin);
            sr     = int'($signed(a)) + int'($signed(b)) + int'(cin);
            t.cout = r[W];
        end
        t.sum  = r[W-1:0];
        t.ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        t.zero = (t.sum == '0);
        t.acc  = 0;
        return t;
    endfunction

    function automatic beat_t dbeat(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub,
                                    input logic [W-1:0] sum, input logic cout,
                                    input logic ovf, input logic zero);
        beat_t t;
        t.a    = a;
        t.b    = b;
        t.cin  = cin;
        t.sub  = sub;
        t.sum  = sum;
        t.cout = cout;
        t.ovf  = ovf;
        t.zero = zero;
        t.acc  = 0;
        return t;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic beat_t rb();
        return model(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // One clock cycle: drive, check outputs against the scoreboard, then take the edge.
    task automatic cyc(input logic iv, input beat_t bt, input logic ordy, input bit lat);
        beat_t f;
        logic  exp_rdy;
        IN_VALID  = iv;
        A         = bt.a;
        B         = bt.b;
        CIN       = bt.cin;
        SUB       = bt.sub;
        OUT_READY = ordy;
        #1;
        exp_rdy = RST_N & (~OUT_VALID | OUT_READY);
        chk("in_ready", IN_READY, exp_rdy);
        if (OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", OUT_VALID, 0);
            end else begin
                f = exp_q[0];
                chk("sum", SUM, f.sum);
                chk("cout", COUT, f.cout);
                chk("ovf", OVF, f.ovf);
                chk("zero", ZERO, f.zero);
                if (OUT_READY) begin
                    if (lat) chk("latency", cycle_cnt - f.acc, S);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (IN_VALID && IN_READY === 1'b1) begin
            f     = bt;
            f.acc = cycle_cnt + 1;
            exp_q.push_back(f);
        end
        @(posedge CLK);
        #1;
        cycle_cnt++;
        if (!RST_N) exp_q.delete();
    endtask

    task automatic drain(input bit lat);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, idle, 1'b1, lat);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        idle      = model('0, '0, 1'b0, 1'b0);
        RST_N     = 1'b0;
        IN_VALID  = 1'b1;
        A         = 16'h1234;
        B         = 16'h4321;
        CIN       = 1'b1;
        SUB       = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_zero", ZERO, 0);
        RST_N = 1'b1;
        cyc(1'b0, idle, 1'b1, 1'b0);

        // Back-to-back adds, fixed latency
        cyc(1'b1, dbeat(16'd100, 16'd155, 1'b0, 1'b0, 16'd255, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'd62,  16'd2,   1'b0, 1'b0, 16'd64,  1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'd10,  16'd4,   1'b1, 1'b0, 16'd15,  1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'd1,   16'd9,   1'b0, 1'b0, 16'd10,  1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        drain(1'b1);

        // Subtract and flag corners
        cyc(1'b1, dbeat(16'd62,   16'd2,  1'b0, 1'b1, 16'd60,   1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'd2,    16'd62, 1'b0, 1'b1, 16'hFFC4, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'd5,    16'd5,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'h7FFF, 16'd1,  1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
        cyc(1'b1, dbeat(16'hFFFF, 16'd1,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1);
        drain(1'b1);

        // Backpressure mid-stream
        for (int i = 0; i < 4; i++) cyc(1'b1, rb(), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, rb(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, rb(), 1'b1, 1'b0);
        drain(1'b0);

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, rb(), 1'b1, 1'b0);
        RST_N = 1'b0;
        cyc(1'b1, rb(), 1'b1, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < S + 3; i++) cyc(1'b0, idle, 1'b1, 1'b0);
        cyc(1'b1, dbeat(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
        drain(1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), rb(), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
